// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants used by the key-schedule blocks.
//   NB, NK : words per block / words per cipher key (AES-128)
//   SBOX   : forward S-box, indexed by input byte
//   RCON   : round constant top byte, indexed by round number (entry 0 and
//            entries past 10 are zero so any 4-bit index is safe)
package aes_pkg;
  localparam int NB = 4;
  localparam int NK = 4;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
endpackage

// File: rtl/inv_key_sched_pkg.sv
// inv_key_sched_pkg: FSM state encoding for the reverse key schedule.
package inv_key_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    STEP = 2'd2
  } state_t;
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box, one byte.
//   din  : input byte
//   dout : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = SBOX[din];
endmodule

// File: rtl/inv_key_sched.sv
// inv_key_sched: walks the AES-128 key schedule backwards from the last
// round key, presenting one round key per beat (round NR down to 0) on a
// valid/ready stream.
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a schedule (sampled only while idle)
//   key_in      : round-NR key, word 0 in bits 0..31
//   busy        : not idle
//   key_valid / key_ready : beat handshake
//   key_out, round_out, key_last : beat payload; key_last marks round 0
// Build option INV_KEY_SCHED_ROUND0_ONLY_EN: suppress beats NR..1, stepping
// back-to-back and presenting only the round-0 (cipher) key.
module inv_key_sched
  import aes_pkg::*;
  import inv_key_sched_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [0:127] key_out,
  output logic [0:3]   round_out,
  output logic         key_last
);
  state_t            state;
  logic [0:127]      key_q;
  logic [3:0]        rnd_q;
  logic              vld_q;
  logic              last_q;

  // current round words, w[0] is the most significant word
  logic [0:NK-1][31:0] w;
  logic [31:0]         p0, p1, p2, p3, rot, sub;
  logic [0:127]        prev;

  assign w  = key_q;
  assign p3 = w[3] ^ w[2];
  assign p2 = w[2] ^ w[1];
  assign p1 = w[1] ^ w[0];
  assign rot = {p3[23:0], p3[31:24]};

  genvar i;
  for (i = 0; i < NB; i++) begin : g_sub
    aes_sbox u_sbox (.din(rot[8*i +: 8]), .dout(sub[8*i +: 8]));
  end

  // rcon of the round being undone (the one that produced key_q)
  assign p0   = w[0] ^ sub ^ {RCON[rnd_q], 24'h0};
  assign prev = {p0, p1, p2, p3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      key_q  <= '0;
      rnd_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q <= key_in;
            rnd_q <= 4'(NR);
`ifdef INV_KEY_SCHED_ROUND0_ONLY_EN
            state <= STEP;
`else
            state <= EMIT;
            vld_q <= 1'b1;
`endif
          end
        end
        EMIT: begin
          if (key_ready) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            state  <= (rnd_q == 4'd0) ? IDLE : STEP;
          end
        end
        STEP: begin
          key_q <= prev;
          rnd_q <= rnd_q - 4'd1;
`ifdef INV_KEY_SCHED_ROUND0_ONLY_EN
          // keep stepping silently until round 0 is reached
          if (rnd_q == 4'd1) begin
            state  <= EMIT;
            vld_q  <= 1'b1;
            last_q <= 1'b1;
          end
`else
          state  <= EMIT;
          vld_q  <= 1'b1;
          last_q <= (rnd_q == 4'd1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign key_valid = vld_q;
  assign key_out   = key_q;
  assign round_out = rnd_q;
  assign key_last  = last_q;
endmodule

// File: tb/tb_inv_key_sched.sv
module tb_inv_key_sched;
  localparam int NR = 10;
`ifdef INV_KEY_SCHED_ROUND0_ONLY_EN
  localparam int LAT = NR + 1;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         key_ready = 1'b1;
  logic [0:127] key_in = '0;
  logic         busy, key_valid, key_last;
  logic [0:127] key_out;
  logic [0:3]   round_out;

  always #5 clk = ~clk;

  inv_key_sched #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy), .key_valid(key_valid), .key_ready(key_ready),
    .key_out(key_out), .round_out(round_out), .key_last(key_last)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
    logic         last;
    logic         chk;
  } beat_t;

  typedef struct {
    logic [127:0]            key;
    logic [10:0][127:0]      rk;
    logic [10:0]             mask;
  } vec_t;

  vec_t  vecs [2];
  beat_t sb [$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // One schedule: push expected beats, start, then watch the stream.
  // stall_round/stall_len : hold key_ready low on that beat
  // start_round           : pulse start (new key) while that beat is shown
  // start_at_end          : pulse start together with the final acceptance
  // rst_cycle             : assert reset at that cycle after start
  task automatic run(input int vi, input int stall_round, input int stall_len,
                     input int start_round, input bit start_at_end, input int rst_cycle);
    int    cyc, stalls, first_lat;
    bit    done, just_acc;
    beat_t b;
    for (int r = NR; r >= 0; r--) begin
`ifdef INV_KEY_SCHED_ROUND0_ONLY_EN
      if (r != 0) continue;
`endif
      b.key  = vecs[vi].rk[r];
      b.rnd  = 4'(r);
      b.last = (r == 0);
      b.chk  = vecs[vi].mask[r];
      sb.push_back(b);
    end
    @(negedge clk);
    key_in = vecs[vi].key; start = 1'b1; key_ready = 1'b1;
    cyc = 0; stalls = 0; first_lat = -1; done = 0; just_acc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == rst_cycle) begin
        check("busy_before_rst", 128'(busy), 128'(1));
        check("valid_in_step", 128'(key_valid), 128'(0));
        rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(key_valid), 128'(0));
        check("rst_last", 128'(key_last), 128'(0));
        check("rst_key", key_out, 128'(0));
        check("rst_round", 128'(round_out), 128'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        done = 1;
      end else begin
        if (just_acc) begin
          check("valid_after_acc", 128'(key_valid), 128'(0));
          just_acc = 0;
          if (sb.size() == 0) begin
            check("busy_after_last", 128'(busy), 128'(0));
            done = 1;
          end
        end
        if (!done && key_valid) begin
          if (first_lat < 0) begin
            first_lat = cyc;
            check("first_latency", 128'(cyc), 128'(LAT));
          end
          if (sb.size() == 0) begin
            check("extra_beat", 128'(key_valid), 128'(0));
            done = 1;
          end else begin
            if (sb[0].chk) check("key_out", key_out, sb[0].key);
            check("round_out", 128'(round_out), 128'(sb[0].rnd));
            check("key_last", 128'(key_last), 128'(sb[0].last));
            key_ready = !(int'(sb[0].rnd) == stall_round && stalls < stall_len);
            if (!key_ready) stalls++;
            if (key_ready) begin
              if (int'(sb[0].rnd) == start_round) begin
                start = 1'b1; key_in = ~key_in;
              end
              if (sb[0].last && start_at_end) start = 1'b1;
              b = sb.pop_front();
              just_acc = 1;
            end
          end
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout got=%0d cycles exp=done", cyc);
    end
    start = 1'b0; key_ready = 1'b1;
    if (stall_len > 0 && LAT == 1) check("stall_cycles", 128'(stalls), 128'(stall_len));
    repeat (2) begin
      @(negedge clk);
      check("idle_no_beat", 128'(key_valid), 128'(0));
    end
  endtask

  initial begin
    vecs[0].key   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vecs[0].mask  = 11'h7ff;
    vecs[0].rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vecs[0].rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    vecs[0].rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    vecs[0].rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    vecs[0].rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    vecs[0].rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    vecs[0].rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    vecs[0].rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    vecs[0].rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    vecs[0].rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    vecs[0].rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[1].key   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    vecs[1].mask  = 11'h401;
    vecs[1].rk    = '0;
    vecs[1].rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    vecs[1].rk[0]  = 128'h0;

    #1;
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_valid", 128'(key_valid), 128'(0));
    check("reset_last", 128'(key_last), 128'(0));
    check("reset_key", key_out, 128'(0));
    check("reset_round", 128'(round_out), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 2; v++) run(v, -1, 0, -1, 1'b0, -1);
    run(0, 9, 5, -1, 1'b0, -1);
    run(0, -1, 0, 5, 1'b1, -1);
    run(0, -1, 0, -1, 1'b0, 10);
    run(0, -1, 0, -1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
